// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: lead counters (fetch position), a pixel-enabled
// delay pipeline, and registered DAC/sync/strobe outputs trailing fetch by LOOKAHEAD+1 ticks.
module vga_timing_gen #(
    parameter int W         = 11,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int LOOKAHEAD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_ce,
    output logic [W-1:0] fetch_x,
    output logic [W-1:0] fetch_y,
    output logic [W-1:0] pixelx,
    output logic [W-1:0] pixely,
    output logic         hsync,
    output logic         vsync,
    output logic         blank,
    output logic         sync,
    output logic         line_start,
    output logic         frame_start,
    output logic         in_vblank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2**W) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in W bits");
    end
    if (V_TOTAL > 2**W) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in W bits");
    end
    if (LOOKAHEAD < 0 || LOOKAHEAD > 7) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD must be within 0..7");
    end

    localparam logic [W-1:0] H_LAST   = W'(H_TOTAL - 1);
    localparam logic [W-1:0] V_LAST   = W'(V_TOTAL - 1);
    // One extra bit so boundaries equal to 2**W still compare correctly.
    localparam logic [W:0]   H_ACT_L  = (W+1)'(H_ACTIVE);
    localparam logic [W:0]   HS_BEG_L = (W+1)'(H_ACTIVE + H_FP);
    localparam logic [W:0]   HS_END_L = (W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [W:0]   V_ACT_L  = (W+1)'(V_ACTIVE);
    localparam logic [W:0]   VS_BEG_L = (W+1)'(V_ACTIVE + V_FP);
    localparam logic [W:0]   VS_END_L = (W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic         HS_ON    = logic'(HS_POL != 0);
    localparam logic         VS_ON    = logic'(VS_POL != 0);

    // valid distinguishes real positions from the cleared post-reset stages.
    typedef struct packed {
        logic         valid;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         vis;
        logic         hs;
        logic         vs;
    } stage_t;

    logic [W-1:0] hx_q, hx_d;
    logic [W-1:0] hy_q, hy_d;

    always_comb begin
        hx_d = hx_q;
        hy_d = hy_q;
        if (pix_ce) begin
            if (hx_q == H_LAST) begin
                hx_d = '0;
                hy_d = (hy_q == V_LAST) ? '0 : hy_q + W'(1);
            end else begin
                hx_d = hx_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hx_q <= '0;
            hy_q <= '0;
        end else begin
            hx_q <= hx_d;
            hy_q <= hy_d;
        end
    end

    assign fetch_x = hx_q;
    assign fetch_y = hy_q;

    stage_t lead_s;
    stage_t tail_s;

    always_comb begin
        lead_s       = '0;
        lead_s.valid = 1'b1;
        lead_s.x     = hx_q;
        lead_s.y     = hy_q;
        lead_s.vis   = ({1'b0, hx_q} < H_ACT_L) && ({1'b0, hy_q} < V_ACT_L);
        lead_s.hs    = ({1'b0, hx_q} >= HS_BEG_L) && ({1'b0, hx_q} < HS_END_L);
        lead_s.vs    = ({1'b0, hy_q} >= VS_BEG_L) && ({1'b0, hy_q} < VS_END_L);
    end

    if (LOOKAHEAD == 0) begin : g_no_pipe
        assign tail_s = lead_s;
    end else begin : g_pipe
        stage_t pipe_q [LOOKAHEAD];
        stage_t pipe_d [LOOKAHEAD];

        always_comb begin
            for (int i = 0; i < LOOKAHEAD; i++) begin
                pipe_d[i] = pipe_q[i];
            end
            if (pix_ce) begin
                pipe_d[0] = lead_s;
                for (int i = 1; i < LOOKAHEAD; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < LOOKAHEAD; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < LOOKAHEAD; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        assign tail_s = pipe_q[LOOKAHEAD-1];
    end

    logic [W-1:0] pixelx_q, pixelx_d;
    logic [W-1:0] pixely_q, pixely_d;
    logic         hsync_q, hsync_d;
    logic         vsync_q, vsync_d;
    logic         blank_q, blank_d;
    logic         line_start_q, line_start_d;
    logic         frame_start_q, frame_start_d;
    logic         in_vblank_q, in_vblank_d;

    always_comb begin
        pixelx_d      = pixelx_q;
        pixely_d      = pixely_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_d       = blank_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        in_vblank_d   = in_vblank_q;
        if (pix_ce) begin
            pixelx_d      = tail_s.x;
            pixely_d      = tail_s.y;
            hsync_d       = tail_s.hs ? HS_ON : ~HS_ON;
            vsync_d       = tail_s.vs ? VS_ON : ~VS_ON;
            blank_d       = tail_s.vis;
            line_start_d  = tail_s.valid && (tail_s.x == '0);
            frame_start_d = tail_s.valid && (tail_s.x == '0) && (tail_s.y == '0);
            in_vblank_d   = tail_s.valid && ({1'b0, tail_s.y} >= V_ACT_L);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixelx_q      <= '0;
            pixely_q      <= '0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            in_vblank_q   <= 1'b0;
        end else begin
            pixelx_q      <= pixelx_d;
            pixely_q      <= pixely_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            in_vblank_q   <= in_vblank_d;
        end
    end

    assign pixelx      = pixelx_q;
    assign pixely      = pixely_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign sync        = 1'b1;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign in_vblank   = in_vblank_q;

endmodule
